// File: rtl/stack_unit.sv
// stack_unit: parametrised LIFO shared by the Forth core's data and return stacks.
// It is driven by the {change, dec, update} command triple. It tracks occupancy,
// reports full/empty/almost-full status, and keeps sticky overflow/underflow flags.
// Optional feature macro: STACK_PICK_EN adds an indexed, read-only PICK port
// (pick_idx / pick_q / pick_oob). With the macro undefined those ports are absent.
module stack_unit #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned SADDR_WIDTH  = 8,
    parameter int unsigned AFULL_MARGIN = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   change,
    input  logic                   dec,
    input  logic                   update,
    input  logic [WIDTH-1:0]       D,
    output logic [WIDTH-1:0]       Q,
    output logic [SADDR_WIDTH:0]   depth,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   err_clr
`ifdef STACK_PICK_EN
    ,
    input  logic [SADDR_WIDTH-1:0] pick_idx,
    output logic [WIDTH-1:0]       pick_q,
    output logic                   pick_oob
`endif
);

    localparam int unsigned DEPTH       = 2 ** SADDR_WIDTH;
    localparam int unsigned CNT_W       = SADDR_WIDTH + 1;
    // A margin of DEPTH or more would underflow the threshold; clamp it so almost_full is constant 1.
    localparam int unsigned AFULL_LEVEL = (AFULL_MARGIN >= DEPTH) ? 0 : DEPTH - AFULL_MARGIN;

    localparam logic [CNT_W-1:0]       CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]       CNT_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0]       CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]       CNT_AFULL = CNT_W'(AFULL_LEVEL);
    localparam logic [SADDR_WIDTH-1:0] SP_ONE    = SADDR_WIDTH'(1);
    // The pointer starts one below slot 0, so the first push lands in mem[0].
    localparam logic [SADDR_WIDTH-1:0] SP_RESET  = SADDR_WIDTH'(DEPTH - 1);

    // Command encodings: {change, dec, update}. With change=0, dec is a don't-care.
    localparam logic [2:0] CMD_NOP_A     = 3'b000;
    localparam logic [2:0] CMD_NOP_B     = 3'b010;
    localparam logic [2:0] CMD_REPLACE_A = 3'b001;
    localparam logic [2:0] CMD_REPLACE_B = 3'b011;
    localparam logic [2:0] CMD_RESERVE   = 3'b100;
    localparam logic [2:0] CMD_PUSH      = 3'b101;
    localparam logic [2:0] CMD_POP       = 3'b110;
    localparam logic [2:0] CMD_POP_WR    = 3'b111;

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [SADDR_WIDTH-1:0] sp;
    logic [CNT_W-1:0]       cnt;

    logic [SADDR_WIDTH-1:0] sp_nxt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   wr_en;
    logic [SADDR_WIDTH-1:0] wr_addr;
    logic                   ovf_set;
    logic                   udf_set;
    logic [SADDR_WIDTH-1:0] sp_inc;
    logic [SADDR_WIDTH-1:0] sp_dec;
    logic [2:0]             cmd;

    assign cmd    = {change, dec, update};
    assign sp_inc = sp + SP_ONE;
    assign sp_dec = sp - SP_ONE;

    // Decode the command into the next pointer, the next count, a write and an error request.
    always_comb begin
        sp_nxt  = sp;
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_addr = sp;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        case (cmd)
            CMD_NOP_A, CMD_NOP_B: begin
            end
            CMD_REPLACE_A, CMD_REPLACE_B: begin
                if (cnt == CNT_ZERO) begin
                    udf_set = 1'b1;
                end else begin
                    wr_en = 1'b1;
                end
            end
            CMD_RESERVE: begin
                if (cnt == CNT_FULL) begin
                    ovf_set = 1'b1;
                end else begin
                    sp_nxt  = sp_inc;
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            CMD_PUSH: begin
                if (cnt == CNT_FULL) begin
                    ovf_set = 1'b1;
                end else begin
                    sp_nxt  = sp_inc;
                    cnt_nxt = cnt + CNT_ONE;
                    wr_en   = 1'b1;
                    wr_addr = sp_inc;
                end
            end
            CMD_POP: begin
                if (cnt == CNT_ZERO) begin
                    udf_set = 1'b1;
                end else begin
                    sp_nxt  = sp_dec;
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            CMD_POP_WR: begin
                // The new top must already exist, so at least two entries are required.
                if (cnt < CNT_TWO) begin
                    udf_set = 1'b1;
                end else begin
                    sp_nxt  = sp_dec;
                    cnt_nxt = cnt - CNT_ONE;
                    wr_en   = 1'b1;
                    wr_addr = sp_dec;
                end
            end
            default: begin
            end
        endcase
    end

    // Update the pointer, the count and the sticky error flags. A new error wins over err_clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp        <= SP_RESET;
            cnt       <= CNT_ZERO;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_nxt;
            cnt       <= cnt_nxt;
            overflow  <= ovf_set | (overflow  & ~err_clr);
            underflow <= udf_set | (underflow & ~err_clr);
        end
    end

    // Write the entry storage. It has no reset, and a write that coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && reset_n) begin
            mem[wr_addr] <= D;
        end
    end

    // Drive the top-of-stack and status outputs straight from the current state.
    assign Q           = (cnt == CNT_ZERO) ? '0 : mem[sp];
    assign depth       = cnt;
    assign empty       = (cnt == CNT_ZERO);
    assign full        = (cnt == CNT_FULL);
    assign almost_full = (cnt >= CNT_AFULL);

`ifdef STACK_PICK_EN
    logic [SADDR_WIDTH-1:0] pick_addr;

    // Read an entry by its distance from the top. Indices at or past the occupancy read as zero.
    assign pick_addr = sp - pick_idx;
    assign pick_oob  = ({1'b0, pick_idx} >= cnt);
    assign pick_q    = pick_oob ? '0 : mem[pick_addr];
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Directed testbench for stack_unit (DEPTH=8, AFULL_MARGIN=2, WIDTH=16).
module tb_stack_unit;

    logic        clk;
    logic        reset_n;
    logic        change;
    logic        dec;
    logic        update;
    logic [15:0] D;
    logic [15:0] Q;
    logic [3:0]  depth;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic        overflow;
    logic        underflow;
    logic        err_clr;
`ifdef STACK_PICK_EN
    logic [2:0]  pick_idx;
    logic [15:0] pick_q;
    logic        pick_oob;
`endif

    int n_cmp;
    int n_fail;

    stack_unit #(
        .WIDTH(16),
        .SADDR_WIDTH(3),
        .AFULL_MARGIN(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .change(change),
        .dec(dec),
        .update(update),
        .D(D),
        .Q(Q),
        .depth(depth),
        .empty(empty),
        .full(full),
        .almost_full(almost_full),
        .overflow(overflow),
        .underflow(underflow),
        .err_clr(err_clr)
`ifdef STACK_PICK_EN
        ,
        .pick_idx(pick_idx),
        .pick_q(pick_q),
        .pick_oob(pick_oob)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one command for a single clock edge, then sample 1 time unit after that edge.
    task automatic cmd(input logic c, input logic d, input logic u,
                       input logic [15:0] data, input logic clr);
        @(negedge clk);
        change  = c;
        dec     = d;
        update  = u;
        D       = data;
        err_clr = clr;
        @(posedge clk);
        #1;
        change  = 1'b0;
        dec     = 1'b0;
        update  = 1'b0;
        D       = 16'h0000;
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth got %0d want 0", depth); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_cmp++; if (Q !== 16'h0000) begin n_fail++; $display("FAIL reset_q got %h want 0000", Q); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b want 0", almost_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_udf got %b want 0", underflow); end
    endtask

    task automatic test_push_pop();
        do_reset();
        cmd(1, 0, 1, 16'h1111, 0);
        cmd(1, 0, 1, 16'h2222, 0);
        cmd(1, 0, 1, 16'h3333, 0);
        n_cmp++; if (Q !== 16'h3333) begin n_fail++; $display("FAIL push3_q got %h want 3333", Q); end
        n_cmp++; if (depth !== 4'd3) begin n_fail++; $display("FAIL push3_depth got %0d want 3", depth); end
        cmd(1, 1, 0, 16'h0000, 0);
        n_cmp++; if (Q !== 16'h2222) begin n_fail++; $display("FAIL pop_q got %h want 2222", Q); end
        n_cmp++; if (depth !== 4'd2) begin n_fail++; $display("FAIL pop_depth got %0d want 2", depth); end
        cmd(1, 1, 1, 16'hAAAA, 0);
        n_cmp++; if (Q !== 16'hAAAA) begin n_fail++; $display("FAIL popwr_q got %h want aaaa", Q); end
        n_cmp++; if (depth !== 4'd1) begin n_fail++; $display("FAIL popwr_depth got %0d want 1", depth); end
        cmd(0, 0, 1, 16'h5555, 0);
        n_cmp++; if (Q !== 16'h5555) begin n_fail++; $display("FAIL replace_q got %h want 5555", Q); end
        n_cmp++; if (depth !== 4'd1) begin n_fail++; $display("FAIL replace_depth got %0d want 1", depth); end
        // RESERVE exposes the old contents of slot 1, which still holds 2222.
        cmd(1, 0, 0, 16'hFFFF, 0);
        n_cmp++; if (Q !== 16'h2222) begin n_fail++; $display("FAIL reserve_q got %h want 2222", Q); end
        n_cmp++; if (depth !== 4'd2) begin n_fail++; $display("FAIL reserve_depth got %0d want 2", depth); end
        cmd(1, 1, 0, 16'h0000, 0);
        n_cmp++; if (Q !== 16'h5555) begin n_fail++; $display("FAIL pop2_q got %h want 5555", Q); end
        cmd(1, 1, 0, 16'h0000, 0);
        n_cmp++; if (Q !== 16'h0000) begin n_fail++; $display("FAIL pop_empty_q got %h want 0000", Q); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty got %b want 1", empty); end
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL push_pop_udf got %b want 0", underflow); end
    endtask

    task automatic test_full();
        logic [15:0] v;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            v = 16'h0100 + 16'(i);
            cmd(1, 0, 1, v, 0);
            n_cmp++; if (depth !== 4'(i)) begin n_fail++; $display("FAIL fill_depth[%0d] got %0d want %0d", i, depth, i); end
            n_cmp++; if (almost_full !== (i >= 6)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b want %b", i, almost_full, (i >= 6)); end
            n_cmp++; if (full !== (i == 8)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 8)); end
            n_cmp++; if (Q !== v) begin n_fail++; $display("FAIL fill_q[%0d] got %h want %h", i, Q, v); end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf got %b want 0", overflow); end
        cmd(1, 0, 1, 16'hDEAD, 0);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL push9_ovf got %b want 1", overflow); end
        n_cmp++; if (depth !== 4'd8) begin n_fail++; $display("FAIL push9_depth got %0d want 8", depth); end
        n_cmp++; if (Q !== 16'h0108) begin n_fail++; $display("FAIL push9_q got %h want 0108", Q); end
        cmd(0, 0, 0, 16'h0000, 0);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL full_udf got %b want 0", underflow); end
    endtask

    task automatic test_err_clr();
        // The stack is still full from test_full, and overflow is set.
        cmd(0, 0, 0, 16'h0000, 1);
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b want 0", overflow); end
        cmd(1, 0, 1, 16'hBEEF, 1);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set_ovf got %b want 1", overflow); end
        n_cmp++; if (Q !== 16'h0108) begin n_fail++; $display("FAIL clr_vs_set_q got %h want 0108", Q); end
        cmd(0, 0, 0, 16'h0000, 1);
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf2 got %b want 0", overflow); end
    endtask

    task automatic test_underflow();
        do_reset();
        cmd(1, 1, 0, 16'h0000, 0);
        n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL pop0_udf got %b want 1", underflow); end
        n_cmp++; if (depth !== 4'd0) begin n_fail++; $display("FAIL pop0_depth got %0d want 0", depth); end
        cmd(0, 0, 0, 16'h0000, 1);
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL udf_clr got %b want 0", underflow); end
        cmd(0, 0, 1, 16'h4444, 0);
        n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL repl0_udf got %b want 1", underflow); end
        n_cmp++; if (depth !== 4'd0) begin n_fail++; $display("FAIL repl0_depth got %0d want 0", depth); end
        n_cmp++; if (Q !== 16'h0000) begin n_fail++; $display("FAIL repl0_q got %h want 0000", Q); end
        cmd(0, 0, 0, 16'h0000, 1);
        cmd(1, 0, 1, 16'h7777, 0);
        cmd(1, 1, 1, 16'h8888, 0);
        n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL popwr1_udf got %b want 1", underflow); end
        n_cmp++; if (Q !== 16'h7777) begin n_fail++; $display("FAIL popwr1_q got %h want 7777", Q); end
        n_cmp++; if (depth !== 4'd1) begin n_fail++; $display("FAIL popwr1_depth got %0d want 1", depth); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL udf_ovf got %b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cmd(1, 0, 1, 16'h1234, 0);
        cmd(1, 0, 1, 16'h5678, 0);
        n_cmp++; if (depth !== 4'd2) begin n_fail++; $display("FAIL pre_rst_depth got %0d want 2", depth); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (depth !== 4'd0) begin n_fail++; $display("FAIL async_rst_depth got %0d want 0", depth); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL async_rst_empty got %b want 1", empty); end
        n_cmp++; if (Q !== 16'h0000) begin n_fail++; $display("FAIL async_rst_q got %h want 0000", Q); end
        @(negedge clk);
        reset_n = 1'b1;
        cmd(1, 0, 1, 16'h9ABC, 0);
        n_cmp++; if (Q !== 16'h9ABC) begin n_fail++; $display("FAIL post_rst_q got %h want 9abc", Q); end
        n_cmp++; if (depth !== 4'd1) begin n_fail++; $display("FAIL post_rst_depth got %0d want 1", depth); end
    endtask

`ifdef STACK_PICK_EN
    task automatic test_pick();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cmd(1, 0, 1, 16'(i), 0);
        end
        pick_idx = 3'd0; #1;
        n_cmp++; if (pick_q !== 16'd5) begin n_fail++; $display("FAIL pick0_q got %h want 0005", pick_q); end
        n_cmp++; if (pick_oob !== 1'b0) begin n_fail++; $display("FAIL pick0_oob got %b want 0", pick_oob); end
        pick_idx = 3'd2; #1;
        n_cmp++; if (pick_q !== 16'd3) begin n_fail++; $display("FAIL pick2_q got %h want 0003", pick_q); end
        pick_idx = 3'd4; #1;
        n_cmp++; if (pick_q !== 16'd1) begin n_fail++; $display("FAIL pick4_q got %h want 0001", pick_q); end
        pick_idx = 3'd5; #1;
        n_cmp++; if (pick_q !== 16'd0) begin n_fail++; $display("FAIL pick5_q got %h want 0000", pick_q); end
        n_cmp++; if (pick_oob !== 1'b1) begin n_fail++; $display("FAIL pick5_oob got %b want 1", pick_oob); end
        n_cmp++; if (depth !== 4'd5) begin n_fail++; $display("FAIL pick_depth got %0d want 5", depth); end
        pick_idx = 3'd0;
    endtask
`endif

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        reset_n = 1'b1;
        change  = 1'b0;
        dec     = 1'b0;
        update  = 1'b0;
        D       = 16'h0000;
        err_clr = 1'b0;
`ifdef STACK_PICK_EN
        pick_idx = 3'd0;
`endif
        #1;
        reset_n = 1'b0;
        test_reset();
        test_push_pop();
        test_full();
        test_err_clr();
        test_underflow();
        test_reset_mid();
`ifdef STACK_PICK_EN
        test_pick();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
